// File: rtl/cam_match_array_if.sv
// Port bundle for the CAM storage/compare stage: update, clear and search signals.
// The master drives requests; the slave returns busy and the registered match vector.
interface cam_match_array_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned KEY_WIDTH  = 16
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [KEY_WIDTH-1:0]  wr_key;
  logic                  inv_en;
  logic [ADDR_WIDTH-1:0] inv_addr;
  logic                  clear_start;
  logic                  busy;
  logic                  search_en;
  logic [KEY_WIDTH-1:0]  search_key;
  logic [DEPTH-1:0]      match_out;
  logic                  match_valid;

  modport master (
    output wr_en, wr_addr, wr_key, inv_en, inv_addr, clear_start, search_en, search_key,
    input  busy, match_out, match_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_key, inv_en, inv_addr, clear_start, search_en, search_key,
    output busy, match_out, match_valid
  );
endinterface

// File: rtl/cam_match_array.sv
// CAM storage and parallel compare: keyed entries with valid bits, a registered match vector
// for the downstream priority encoder, and a one-entry-per-cycle full-array clear walker.
module cam_match_array #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned KEY_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst_n,
  cam_match_array_if.slave  bus
);

  typedef enum logic {StIdle, StClear} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  busy_q;
  logic                  match_valid_q;
  logic [DEPTH-1:0]      match_q, match_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [KEY_WIDTH-1:0]  key_q [DEPTH];

  // Compare uses pre-edge storage, so same-cycle updates are invisible to the search.
  always_comb begin
    match_d = '0;
    if (!busy_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        match_d[i] = valid_q[i] && (key_q[i] == bus.search_key);
      end
    end
  end

  // Invalidate is applied before write so a same-address write wins.
  always_comb begin
    valid_d = valid_q;
    if (state_q == StClear) begin
      valid_d[idx_q] = 1'b0;
    end else begin
      if (bus.inv_en) valid_d[bus.inv_addr] = 1'b0;
      if (bus.wr_en)  valid_d[bus.wr_addr]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.clear_start) begin
            state_q <= StClear;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          idx_q <= idx_q + ADDR_WIDTH'(1);
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      match_q       <= '0;
      match_valid_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      match_valid_q <= bus.search_en;
      if (bus.search_en) match_q <= match_d;
    end
  end

  // Key storage carries no reset; stale keys are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) key_q[bus.wr_addr] <= bus.wr_key;
  end

  assign bus.busy        = busy_q;
  assign bus.match_out   = match_q;
  assign bus.match_valid = match_valid_q;

endmodule

// File: tb/tb_cam_match_array.sv
// Self-checking bench for cam_match_array: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against an array-based reference model.
module tb_cam_match_array;

  localparam int unsigned AW = 3;
  localparam int unsigned D  = 8;
  localparam int unsigned KW = 8;

  logic clk;
  logic rst_n;

  cam_match_array_if #(.ADDR_WIDTH(AW), .DEPTH(D), .KEY_WIDTH(KW)) ifc ();

  cam_match_array #(.ADDR_WIDTH(AW), .DEPTH(D), .KEY_WIDTH(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain arrays, a remaining-cycles clear counter.
  logic [KW-1:0] m_key [D];
  bit            m_valid [D];
  int            m_clr;
  logic [D-1:0]  m_match;
  bit            m_mv;
  bit            m_busy_now;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
        m_clr   = 0;
        m_match = '0;
        m_mv    = 1'b0;
      end else begin
        m_busy_now = (m_clr != 0);
        m_mv = ifc.search_en;
        if (ifc.search_en) begin
          m_match = '0;
          if (!m_busy_now) begin
            for (int i = 0; i < D; i++) begin
              if (m_valid[i] && m_key[i] == ifc.search_key) m_match[i] = 1'b1;
            end
          end
        end
        if (m_busy_now) begin
          m_valid[D - m_clr] = 1'b0;
          m_clr--;
        end else begin
          if (ifc.clear_start) m_clr = D;
          if (ifc.inv_en) m_valid[ifc.inv_addr] = 1'b0;
          if (ifc.wr_en) begin
            m_key[ifc.wr_addr]   = ifc.wr_key;
            m_valid[ifc.wr_addr] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("model_busy",        {31'd0, ifc.busy},        {31'd0, m_clr != 0});
        chk("model_match_valid", {31'd0, ifc.match_valid}, {31'd0, m_mv});
        chk("model_match_out",   {24'd0, ifc.match_out},   {24'd0, m_match});
      end
    end
  end

  task automatic idle();
    ifc.wr_en       = 1'b0;
    ifc.inv_en      = 1'b0;
    ifc.clear_start = 1'b0;
    ifc.search_en   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input int a, input int k);
    ifc.wr_en = 1'b1;  ifc.wr_addr = AW'(a);  ifc.wr_key = KW'(k);
    tick();
  endtask

  task automatic srch(input string name, input int k, input int exp);
    ifc.search_en = 1'b1;  ifc.search_key = KW'(k);
    tick();
    chk(name, {24'd0, ifc.match_out}, exp);
    chk({name, "_mv"}, {31'd0, ifc.match_valid}, 32'd1);
  endtask

  int busy_cnt;

  initial begin
    rst_n = 1'b0;
    ifc.wr_addr = '0; ifc.wr_key = '0; ifc.inv_addr = '0; ifc.search_key = '0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_match_out", {24'd0, ifc.match_out}, 32'h0);
    chk("rst_match_valid", {31'd0, ifc.match_valid}, 32'd0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    rst_n = 1'b1;

    srch("reset_search", 8'h00, 8'h00);
    tick();
    chk("mv_one_cycle", {31'd0, ifc.match_valid}, 32'd0);
    chk("busy_idle", {31'd0, ifc.busy}, 32'd0);

    wr(2, 8'h5A);
    wr(6, 8'h5A);
    srch("hit_5a", 8'h5A, 8'h44);
    srch("miss_11", 8'h11, 8'h00);

    ifc.wr_en = 1'b1; ifc.wr_addr = 3'd3; ifc.wr_key = 8'h77;
    srch("rbw_same_cycle", 8'h77, 8'h00);
    srch("rbw_next", 8'h77, 8'h08);

    ifc.inv_en = 1'b1; ifc.inv_addr = 3'd5;
    wr(5, 8'h33);
    srch("wr_beats_inv", 8'h33, 8'h20);
    ifc.inv_en = 1'b1; ifc.inv_addr = 3'd5;
    tick();
    srch("inv_alone", 8'h33, 8'h00);

    for (int i = 0; i < D; i++) wr(i, 8'hAA);
    srch("filled", 8'hAA, 8'hFF);
    ifc.clear_start = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ifc.busy) break;
      busy_cnt++;
      if (i == 1) begin
        ifc.search_en = 1'b1; ifc.search_key = 8'hAA;
      end
      if (i == 6) begin
        ifc.wr_en = 1'b1; ifc.wr_addr = 3'd1; ifc.wr_key = 8'hAA;
      end
      tick();
      if (i == 1) begin
        chk("busy_search", {24'd0, ifc.match_out}, 32'h0);
        chk("busy_search_mv", {31'd0, ifc.match_valid}, 32'd1);
      end
    end
    chk("busy_cycles", busy_cnt, 32'd8);
    srch("after_clear", 8'hAA, 8'h00);

    for (int i = 0; i < D; i++) wr(i, 8'hAA);
    srch("refill", 8'hAA, 8'hFF);
    ifc.clear_start = 1'b1;
    tick();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midclr_busy", {31'd0, ifc.busy}, 32'd0);
    chk("midclr_match", {24'd0, ifc.match_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    srch("post_reset", 8'hAA, 8'h00);

    for (int c = 0; c < 1500; c++) begin
      ifc.wr_en       = ($urandom_range(0, 2) == 0);
      ifc.wr_addr     = AW'($urandom_range(0, D - 1));
      ifc.wr_key      = KW'($urandom_range(0, 3));
      ifc.inv_en      = ($urandom_range(0, 3) == 0);
      ifc.inv_addr    = AW'($urandom_range(0, D - 1));
      ifc.search_en   = ($urandom_range(0, 1) == 0);
      ifc.search_key  = KW'($urandom_range(0, 3));
      ifc.clear_start = ($urandom_range(0, 59) == 0);
      tick();
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
